// File: rtl/shift_pkg.sv
// Shared definitions for the shift pipeline: operation encodings and
// helpers used by the top and the per-stage register.
package shift_pkg;

    // Operation select carried on the mode port and into every stage.
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Effective stage command: enable low turns any mode into HOLD.
    function automatic mode_e effective_mode(input logic en, input logic [1:0] mode);
        return en ? mode_e'(mode) : MODE_HOLD;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit.
// Ports:
//   clock, reset_n   - rising-edge clock, async active-low reset
//   sel              - stage command (HOLD/SHIFT/LOAD/CLEAR)
//   shift_in/valid_in- predecessor data/valid, taken on SHIFT
//   load_in          - parallel data, taken on LOAD (valid forced to 1)
//   data/valid       - registered stage contents
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  mode_e            sel,
    input  logic [WIDTH-1:0] shift_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] load_in,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Stage register; HOLD keeps the current contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (sel)
                MODE_SHIFT: begin
                    data  <= shift_in;
                    valid <= valid_in;
                end
                MODE_LOAD: begin
                    data  <= load_in;
                    valid <= 1'b1;
                end
                MODE_CLEAR: begin
                    data  <= '0;
                    valid <= 1'b0;
                end
                default: begin
                    data  <= data;
                    valid <= valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipeline.sv
// Multi-stage shift register with serial shift, parallel load and clear.
// Ports:
//   clock, reset_n   - rising-edge clock, async active-low reset
//   en, mode         - enable and operation select (HOLD/SHIFT/LOAD/CLEAR)
//   d, valid_in      - serial data and its qualifier into stage 0
//   load_data        - parallel data, stage i at [i*WIDTH +: WIDTH]
//   taps             - all stage contents, same packing as load_data
//   q, valid_out     - contents and valid bit of the last stage
//   fill_count, full - number of valid stages, and all-stages-valid flag
module shift_pipeline
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       valid_in,
    input  logic [WIDTH*DEPTH-1:0]     load_data,
    output logic [WIDTH*DEPTH-1:0]     taps,
    output logic [WIDTH-1:0]           q,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Element 0 is the serial input; element i+1 is the output of stage i.
    logic [WIDTH-1:0] data_chain  [DEPTH+1];
    logic             valid_chain [DEPTH+1];
    mode_e            sel;

    assign sel            = effective_mode(en, mode);
    assign data_chain[0]  = d;
    assign valid_chain[0] = valid_in;

    // Each stage samples its predecessor's pre-edge register value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset_n  (reset_n),
            .sel      (sel),
            .shift_in (data_chain[i]),
            .valid_in (valid_chain[i]),
            .load_in  (load_data[i*WIDTH +: WIDTH]),
            .data     (data_chain[i+1]),
            .valid    (valid_chain[i+1])
        );
        assign taps[i*WIDTH +: WIDTH] = data_chain[i+1];
    end

    assign q         = data_chain[DEPTH];
    assign valid_out = valid_chain[DEPTH];

    // Occupancy is the popcount of the stage valid bits.
    always_comb begin
        fill_count = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            fill_count = fill_count + CNT_W'(valid_chain[i]);
        end
    end

    assign full = (fill_count == CNT_W'(DEPTH));

endmodule
